huff_freq_counter: RTL
======================

HUFF_FREQ_COUNTER -- requirements
Module: huff_freq_counter

Interface
REQ-001 SHALL have ports, in order: clk (input, 1, sole clock); reset (input, 1, synchronous active-high reset).
REQ-002 SHALL have sym_in (input, 8): ASCII symbol of the input stream.
REQ-003 SHALL have sym_valid (input, 1): sym_in is valid.
REQ-004 SHALL have sym_last (input, 1): current symbol is the last one of the frame.
REQ-005 SHALL have sym_ready (output, 1): block accepts a symbol this cycle.
REQ-006 SHALL have data_out (output, 24): slot i symbol at bits [(2-i)*8 +: 8]; slot 0 is [23:16].
REQ-007 SHALL have freq_out (output, 9): slot i count at bits [(2-i)*3 +: 3]; slot 0 is [8:6].
REQ-008 SHALL have out_valid (input-facing output, 1): data_out, freq_out and err are a complete frame result.
REQ-009 SHALL have out_ready (input, 1): the downstream Huffman encoder consumes the result.
REQ-010 SHALL have err (output, 1): frame overflow flag, valid while out_valid=1.
REQ-011 One clock; reset is synchronous and active-high.

Function
REQ-012 SHALL implement states IDLE, COUNT and HOLD.
REQ-013 A symbol SHALL be accepted only when sym_valid=1 and sym_ready=1.
REQ-014 sym_ready SHALL be 1 in IDLE and COUNT, and 0 in HOLD and during reset.
REQ-015 IDLE SHALL move to COUNT on an accepted symbol with sym_last=0, and to HOLD on an accepted symbol with sym_last=1.
REQ-016 COUNT SHALL move to HOLD on an accepted symbol with sym_last=1, and stay in COUNT otherwise.
REQ-017 An accepted symbol matching an occupied slot SHALL increment that slot's count by 1.
REQ-018 An accepted symbol with no match SHALL allocate the lowest free slot with count 1; slots fill in arrival order 0, 1, 2.
REQ-019 A 4th distinct symbol SHALL be dropped, leave all slots unchanged and set err; counting SHALL continue until sym_last.
REQ-020 Counts SHALL saturate at 7 and never wrap.
REQ-021 Unused slots SHALL output symbol 8'h00 and count 3'd0.
REQ-022 out_valid SHALL assert in the cycle after the accepted sym_last symbol (latency 1), with that symbol already counted.
REQ-023 In HOLD, out_valid, data_out, freq_out and err SHALL stay stable until out_ready=1.
REQ-024 HOLD with out_ready=1 SHALL clear all slots and err, then move to IDLE in the next cycle.
REQ-025 Match, allocate and increment SHALL resolve in the same cycle as acceptance; slot-match compares use registered slot state.

Reset
REQ-026 On reset the block SHALL enter IDLE and clear all slots and counts.
REQ-027 On reset data_out=0, freq_out=0, out_valid=0, err=0 and sym_ready=0.
REQ-028 Reset mid-frame or in HOLD SHALL discard the partial or pending result.
REQ-029 Reset SHALL take priority over every other event in the same cycle.

Configuration
REQ-030 Macro HUFF_SAT_ERR_EN, when defined, SHALL make an increment attempted at count 7 set err; the count stays at 7.
REQ-031 Without HUFF_SAT_ERR_EN, saturation SHALL be silent; err reflects only the 4th-distinct-symbol overflow.

Structure
REQ-032 Package huff_pkg SHALL hold NUM_SYM=3, SYM_W=8, FREQ_W=3 and the state enum, shared with the Huffman encoder.
REQ-033 Sub-module huff_slot_match SHALL be combinational and give a 3-bit hit vector plus a free-slot index from sym_in and the slot state.

Verification
REQ-034 Frame "AABAC" (last on C), out_ready=1 -> data_out=24'h414243, freq_out=9'h0C9, err=0, out_valid one cycle after the C handshake.
REQ-035 Frame of 9 'A' (last on 9th) -> data_out=24'h410000, freq_out=9'h1C0; err=1 with HUFF_SAT_ERR_EN, err=0 without.
REQ-036 Frame "ABCD" -> data_out=24'h414243, freq_out=9'h049, err=1.
REQ-037 Frame "AB", out_ready=0 for 5 cycles -> out_valid=1 and outputs constant, sym_ready=0 with sym_valid=1 held; out_ready=1 -> next cycle IDLE, outputs cleared.
REQ-038 "AB" accepted, then reset for 1 cycle, then "C" with last -> data_out=24'h430000, freq_out=9'h040.
REQ-039 Single-symbol frame 'Z' with last in IDLE -> data_out=24'h5A0000, freq_out=9'h040, next frame accepted after the handshake.

Source files
------------

// File: rtl/huff_pkg.sv
// Shared constants, state encoding and helpers for the Huffman front end.
// Shared by the frequency counter and the downstream Huffman encoder.
package huff_pkg;

   localparam int NUM_SYM = 3;
   localparam int SYM_W   = 8;
   localparam int FREQ_W  = 3;
   localparam int IDX_W   = 2;

   localparam logic [FREQ_W-1:0] FREQ_MAX = 3'd7;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_COUNT = 2'd1,
      ST_HOLD  = 2'd2
   } huff_state_e;

   // Saturating increment: a count at FREQ_MAX never wraps back to zero.
   function automatic logic [FREQ_W-1:0] freq_sat_inc(input logic [FREQ_W-1:0] cnt);
      return (cnt == FREQ_MAX) ? cnt : cnt + 3'd1;
   endfunction

endpackage

// File: rtl/huff_freq_counter_if.sv
// Symbol-stream input and frame-result output bundle of huff_freq_counter.
interface huff_freq_counter_if;
   import huff_pkg::*;

   logic [SYM_W-1:0]          sym_in;
   logic                      sym_valid;
   logic                      sym_last;
   logic                      sym_ready;
   logic [NUM_SYM*SYM_W-1:0]  data_out;
   logic [NUM_SYM*FREQ_W-1:0] freq_out;
   logic                      out_valid;
   logic                      out_ready;
   logic                      err;

   modport master (
      output sym_in, sym_valid, sym_last, out_ready,
      input  sym_ready, data_out, freq_out, out_valid, err
   );

   modport slave (
      input  sym_in, sym_valid, sym_last, out_ready,
      output sym_ready, data_out, freq_out, out_valid, err
   );

endinterface

// File: rtl/huff_slot_match.sv
// Combinational slot lookup: per-slot hit vector and lowest free slot index.
module huff_slot_match
   import huff_pkg::*;
(
   input  logic [SYM_W-1:0]                sym_in,
   input  logic [NUM_SYM-1:0][SYM_W-1:0]   slot_sym,
   input  logic [NUM_SYM-1:0][FREQ_W-1:0]  slot_cnt,
   output logic [NUM_SYM-1:0]              hit,
   output logic [IDX_W-1:0]                free_idx,
   output logic                            free_vld
);

   // A slot is occupied iff its count is non-zero; scan downward so the lowest free slot wins.
   always_comb begin
      hit      = '0;
      free_idx = '0;
      free_vld = 1'b0;
      for (int i = NUM_SYM - 1; i >= 0; i--) begin
         hit[i]   = (slot_cnt[i] != 3'd0) && (slot_sym[i] == sym_in);
         free_idx = (slot_cnt[i] == 3'd0) ? IDX_W'(i) : free_idx;
         free_vld = free_vld | (slot_cnt[i] == 3'd0);
      end
   end

endmodule

// File: rtl/huff_freq_counter.sv
// Per-frame symbol frequency counter (3 slots) feeding the Huffman encoder.
// Optional macro HUFF_SAT_ERR_EN: flag err when an increment hits a saturated count.
module huff_freq_counter
   import huff_pkg::*;
(
   input  logic              clk,
   input  logic              reset,
   huff_freq_counter_if.slave bus
);

   localparam logic [1:0] IDLE  = ST_IDLE;
   localparam logic [1:0] COUNT = ST_COUNT;
   localparam logic [1:0] HOLD  = ST_HOLD;

`ifdef HUFF_SAT_ERR_EN
   localparam logic SAT_ERR_EN = 1'b1;
`else
   localparam logic SAT_ERR_EN = 1'b0;
`endif

   logic [1:0]                        state_r, state_s;
   logic [NUM_SYM-1:0][SYM_W-1:0]     sym_r, sym_s;
   logic [NUM_SYM-1:0][FREQ_W-1:0]    cnt_r, cnt_s;
   logic                              err_r, err_s;
   logic                              out_valid_r, out_valid_s;
   logic [NUM_SYM-1:0]                hit_s;
   logic [IDX_W-1:0]                  free_idx_s;
   logic                              free_vld_s;
   logic                              sym_ready_s;
   logic                              accept_s;
   logic [NUM_SYM*SYM_W-1:0]          data_s;
   logic [NUM_SYM*FREQ_W-1:0]         freq_s;

   huff_slot_match u_match (
      .sym_in   (bus.sym_in),
      .slot_sym (sym_r),
      .slot_cnt (cnt_r),
      .hit      (hit_s),
      .free_idx (free_idx_s),
      .free_vld (free_vld_s)
   );

   // Ready is gated by reset so no symbol appears accepted in the reset cycle.
   assign sym_ready_s = (state_r != HOLD) && !reset;
   assign accept_s    = bus.sym_valid && sym_ready_s;

   // Next-state, slot update and error computation for one accepted symbol.
   always_comb begin
      state_s     = state_r;
      sym_s       = sym_r;
      cnt_s       = cnt_r;
      err_s       = err_r;
      out_valid_s = out_valid_r;
      case (state_r)
         IDLE, COUNT: begin
            if (accept_s) begin
               if (|hit_s) begin
                  for (int i = 0; i < NUM_SYM; i++) begin
                     cnt_s[i] = hit_s[i] ? freq_sat_inc(cnt_r[i]) : cnt_r[i];
                     err_s    = err_s | (SAT_ERR_EN && hit_s[i] && (cnt_r[i] == FREQ_MAX));
                  end
               end else if (free_vld_s) begin
                  sym_s[free_idx_s] = bus.sym_in;
                  cnt_s[free_idx_s] = 3'd1;
               end else begin
                  // Fourth distinct symbol: dropped, slots untouched.
                  err_s = 1'b1;
               end
               state_s     = bus.sym_last ? HOLD : COUNT;
               out_valid_s = bus.sym_last;
            end else begin
               state_s = state_r;
            end
         end
         HOLD: begin
            if (bus.out_ready) begin
               sym_s       = '0;
               cnt_s       = '0;
               err_s       = 1'b0;
               out_valid_s = 1'b0;
               state_s     = IDLE;
            end else begin
               state_s = HOLD;
            end
         end
         default: begin
            sym_s       = '0;
            cnt_s       = '0;
            err_s       = 1'b0;
            out_valid_s = 1'b0;
            state_s     = IDLE;
         end
      endcase
   end

   // State and slot registers with synchronous reset taking priority.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_r     <= IDLE;
         sym_r       <= '0;
         cnt_r       <= '0;
         err_r       <= 1'b0;
         out_valid_r <= 1'b0;
      end else begin
         state_r     <= state_s;
         sym_r       <= sym_s;
         cnt_r       <= cnt_s;
         err_r       <= err_s;
         out_valid_r <= out_valid_s;
      end
   end

   // Pack slot registers so slot 0 sits in the most significant field.
   always_comb begin
      data_s = '0;
      freq_s = '0;
      for (int i = 0; i < NUM_SYM; i++) begin
         data_s[(NUM_SYM-1-i)*SYM_W +: SYM_W]   = sym_r[i];
         freq_s[(NUM_SYM-1-i)*FREQ_W +: FREQ_W] = cnt_r[i];
      end
   end

   assign bus.sym_ready = sym_ready_s;
   assign bus.data_out  = data_s;
   assign bus.freq_out  = freq_s;
   assign bus.out_valid = out_valid_r;
   assign bus.err       = err_r;

endmodule
